mem_arbiter: RTL and testbench

Two-port arbiter that shares the single unified instruction/data memory of the multicycle MIPS system between the CPU and a second requester (program loader / debug port). Each requester gets a req/done handshake. The arbiter serialises accesses with round-robin priority and drives the memory's address, write-data and write-enable lines. It also absorbs a configurable memory read latency, so the CPU's memory-ready input is simply its done pulse.

---
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single unified instruction/data memory of the multicycle MIPS
//   system between two requesters: port 0 (CPU) and port 1 (program loader /
//   debug port). Accesses are serialised with round-robin priority. The read
//   latency of the memory (LAT cycles) is absorbed here, so each requester
//   only sees a one-cycle done pulse.
//
// Parameters
//   WIDTH  data and address width in bits
//   LAT    memory read latency in cycles (1..7); writes always take 1 cycle
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   reqN, weN, adrN, wdN   request handshake inputs of port N (held until doneN)
//   doneN                  one-cycle completion pulse for port N
//   rdN                    read data of port N, held until its next read completes
//   mem_adr/mem_wd/mem_we  memory address, write data, write enable
//   mem_rd                 memory read data, valid LAT cycles after the address
//   busy                   high while a transaction is in ACCESS or RESP
//   owner                  port currently granted (0 when idle)

module mem_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] wd0,
  output logic             done0,
  output logic [WIDTH-1:0] rd0,

  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] wd1,
  output logic             done1,
  output logic [WIDTH-1:0] rd1,

  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd,

  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Last ACCESS cycle of a read: the cycle in which mem_rd becomes valid.
  localparam logic [2:0] LAST_CNT = 3'(LAT - 1);

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             last_q;
  logic             owner_q;
  logic             we_q;
  logic [WIDTH-1:0] adr_q;
  logic [WIDTH-1:0] wd_q;
  logic             busy_q;
  logic             mem_we_q;
  logic             done0_q;
  logic             done1_q;
  logic [WIDTH-1:0] rd0_q;
  logic [WIDTH-1:0] rd1_q;

  // Arbitration result and the winner's request fields, used only in IDLE.
  logic             grant_d;
  logic             we_d;
  logic [WIDTH-1:0] adr_d;
  logic [WIDTH-1:0] wd_d;

  always_comb begin
    grant_d = 1'b0;
    if (req0 && req1) begin
      // Contention: the port that did not win last time goes first.
      grant_d = ~last_q;
    end else begin
      grant_d = req1;
    end
    we_d  = grant_d ? we1  : we0;
    adr_d = grant_d ? adr1 : adr0;
    wd_d  = grant_d ? wd1  : wd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wd_q     <= '0;
      busy_q   <= 1'b0;
      mem_we_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      // Pulse-type outputs default low every cycle.
      mem_we_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            owner_q  <= grant_d;
            last_q   <= grant_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wd_q     <= wd_d;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            // mem_we is only ever high in the first ACCESS cycle.
            mem_we_q <= we_d;
            state_q  <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (we_q || (cnt_q == LAST_CNT)) begin
            if (!we_q) begin
              if (owner_q) begin
                rd1_q <= mem_rd;
              end else begin
                rd0_q <= mem_rd;
              end
            end
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        S_RESP: begin
          // Address/data stay visible during RESP and return to zero in IDLE.
          busy_q  <= 1'b0;
          owner_q <= 1'b0;
          we_q    <= 1'b0;
          adr_q   <= '0;
          wd_q    <= '0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done0   = done0_q;
  assign done1   = done1_q;
  assign rd0     = rd0_q;
  assign rd1     = rd1_q;
  assign mem_adr = adr_q;
  assign mem_wd  = wd_q;
  assign mem_we  = mem_we_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LAT=1 and LAT=3), each with its own
// memory model that returns garbage until the address has been held for LAT
// cycles.

module tb_mem_arbiter;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [1:0]        req0, we0, req1, we1;
  logic [1:0][W-1:0] adr0, wd0, adr1, wd1;
  logic [1:0]        done0, done1, mem_we, busy, owner;
  logic [1:0][W-1:0] rd0, rd1, mem_adr, mem_wd, mem_rd;

  bit [W-1:0]  mem [2][256];
  int unsigned hold [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int unsigned lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.WIDTH(W), .LAT((g == 0) ? 1 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0[g]), .we0(we0[g]), .adr0(adr0[g]), .wd0(wd0[g]),
      .done0(done0[g]), .rd0(rd0[g]),
      .req1(req1[g]), .we1(we1[g]), .adr1(adr1[g]), .wd1(wd1[g]),
      .done1(done1[g]), .rd1(rd1[g]),
      .mem_adr(mem_adr[g]), .mem_wd(mem_wd[g]), .mem_we(mem_we[g]),
      .mem_rd(mem_rd[g]),
      .busy(busy[g]), .owner(owner[g])
    );
  end

  // Memory model: writes on mem_we; read data valid only once the address
  // has been presented (busy, not yet done) for LAT cycles.
  always @(posedge clk or posedge reset) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        hold[g] <= 0;
      end else begin
        if (busy[g] && !done0[g] && !done1[g]) hold[g] <= hold[g] + 1;
        else hold[g] <= 0;
        if (mem_we[g]) mem[g][mem_adr[g][9:2]] <= mem_wd[g];
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      mem_rd[g] = (busy[g] && (hold[g] + 1 >= lat_of(g))) ? mem[g][mem_adr[g][9:2]]
                                                          : 32'hBAD0_BAD0;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input int g, input int p, input logic r, input logic w,
                       input logic [W-1:0] a, input logic [W-1:0] d);
    if (p != 0) begin
      req1[g] = r; we1[g] = w; adr1[g] = a; wd1[g] = d;
    end else begin
      req0[g] = r; we0[g] = w; adr0[g] = a; wd0[g] = d;
    end
  endtask

  task automatic check_idle(input int g, input string tag);
    check1($sformatf("%s g%0d busy", tag, g), busy[g], 1'b0);
    check1($sformatf("%s g%0d owner", tag, g), owner[g], 1'b0);
    check1($sformatf("%s g%0d done0", tag, g), done0[g], 1'b0);
    check1($sformatf("%s g%0d done1", tag, g), done1[g], 1'b0);
    check1($sformatf("%s g%0d mem_we", tag, g), mem_we[g], 1'b0);
    check($sformatf("%s g%0d mem_adr", tag, g), mem_adr[g], '0);
    check($sformatf("%s g%0d mem_wd", tag, g), mem_wd[g], '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      drive(g, 0, 1'b0, 1'b0, '0, '0);
      drive(g, 1, 1'b0, 1'b0, '0, '0);
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      check_idle(g, "reset");
      check($sformatf("reset g%0d rd0", g), rd0[g], '0);
      check($sformatf("reset g%0d rd1", g), rd1[g], '0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    int         g;
    bit         port;
    bit         we;
    logic [W-1:0] adr;
    logic [W-1:0] wd;
    int         lat;
    int         acc;
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input int idx);
    int seen = 0;
    int acc = 0;
    int we_cyc = 0;
    int p = int'(v.port);
    drive(v.g, p, 1'b1, v.we, v.adr, v.wd);
    for (int i = 1; i <= 12 && seen == 0; i++) begin
      @(negedge clk);
      if (mem_we[v.g]) we_cyc++;
      if (busy[v.g] && !done0[v.g] && !done1[v.g] && mem_adr[v.g] == v.adr) acc++;
      if (done0[v.g] || done1[v.g]) begin
        seen = i;
        check1($sformatf("vec%0d done1", idx), done1[v.g], v.port);
        check1($sformatf("vec%0d done0", idx), done0[v.g], ~v.port);
        check1($sformatf("vec%0d owner", idx), owner[v.g], v.port);
        check($sformatf("vec%0d resp mem_adr", idx), mem_adr[v.g], v.adr);
        drive(v.g, p, 1'b0, 1'b0, '0, '0);
      end else if (i == 1) begin
        // Granted port's inputs change after the grant; must be ignored.
        drive(v.g, p, 1'b1, ~v.we, $urandom, $urandom);
        drive(v.g, 1 - p, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
      end
    end
    drive(v.g, 0, 1'b0, 1'b0, '0, '0);
    drive(v.g, 1, 1'b0, 1'b0, '0, '0);
    check($sformatf("vec%0d latency", idx), 32'(seen), 32'(v.lat));
    check($sformatf("vec%0d access cycles", idx), 32'(acc), 32'(v.acc));
    check($sformatf("vec%0d mem_we cycles", idx), 32'(we_cyc), 32'(int'(v.we)));
    @(negedge clk);
    check_idle(v.g, $sformatf("vec%0d after", idx));
    check($sformatf("vec%0d rd0", idx), rd0[v.g], v.rd0);
    check($sformatf("vec%0d rd1", idx), rd1[v.g], v.rd1);
  endtask

  // ---------------- hand-written multi-cycle sequences ----------------
  task automatic tie_test();
    int d0 = 0;
    int d1 = 0;
    do_reset();
    drive(1, 0, 1'b1, 1'b0, 32'h100, '0);
    drive(1, 1, 1'b1, 1'b0, 32'h54, '0);
    for (int i = 1; i <= 30 && (d0 == 0 || d1 == 0); i++) begin
      @(negedge clk);
      if (done0[1] && done1[1]) check1("tie both done", 1'b1, 1'b0);
      if (done0[1]) begin
        d0 = i;
        check1("tie owner0", owner[1], 1'b0);
        drive(1, 0, 1'b0, 1'b0, '0, '0);
      end
      if (done1[1]) begin
        d1 = i;
        check1("tie owner1", owner[1], 1'b1);
        drive(1, 1, 1'b0, 1'b0, '0, '0);
      end
    end
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    check("tie done0 cycle", 32'(d0), 32'd4);
    check("tie done1 cycle", 32'(d1), 32'd9);
    check("tie rd0", rd0[1], 32'hDEAD_BEEF);
    check("tie rd1", rd1[1], 32'hA5A5_0001);
  endtask

  task automatic rr_test();
    int seq [$];
    int cyc [$];
    do_reset();
    drive(0, 0, 1'b1, 1'b0, 32'h10, '0);
    drive(0, 1, 1'b1, 1'b0, 32'h56, '0);
    for (int i = 1; i <= 60 && seq.size() < 6; i++) begin
      @(negedge clk);
      check1("rr both done", done0[0] & done1[0], 1'b0);
      if (done0[0] || done1[0]) begin
        seq.push_back(done1[0] ? 1 : 0);
        cyc.push_back(i);
        check1("rr owner", owner[0], done1[0]);
        if (done1[0]) check("rr rd1", rd1[0], 32'h7);
        else          check("rr rd0", rd0[0], 32'h8C02_0004);
      end
    end
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    check("rr count", 32'(seq.size()), 32'd6);
    for (int k = 0; k < seq.size(); k++) begin
      check($sformatf("rr grant%0d", k), 32'(seq[k]), 32'(k % 2));
      if (k == 0) check("rr first done", 32'(cyc[0]), 32'd2);
      else check($sformatf("rr spacing%0d", k), 32'(cyc[k] - cyc[k-1]), 32'd3);
    end
    @(negedge clk);
    @(negedge clk);
    check_idle(0, "rr after");
  endtask

  task automatic mid_reset_test();
    int seen = 0;
    do_reset();
    drive(1, 0, 1'b1, 1'b0, 32'h100, '0);
    @(negedge clk);
    drive(0, 0, 1'b1, 1'b1, 32'h60, 32'h55);
    check1("midrst g1 busy a", busy[1], 1'b1);
    @(negedge clk);
    check1("midrst g1 busy b", busy[1], 1'b1);
    check1("midrst g1 no done", done0[1], 1'b0);
    check1("midrst g0 mem_we", mem_we[0], 1'b1);
    check("midrst g0 mem_adr", mem_adr[0], 32'h60);
    reset = 1'b1;
    #1;
    check_idle(0, "midrst now");
    check_idle(1, "midrst now");
    check("midrst g1 rd0", rd0[1], '0);
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_idle(1, "midrst held");
    reset = 1'b0;
    for (int i = 1; i <= 12 && seen == 0; i++) begin
      @(negedge clk);
      check1("midrst regrant done1", done1[1], 1'b0);
      if (done0[1]) begin
        seen = i;
        drive(1, 0, 1'b0, 1'b0, '0, '0);
      end
    end
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    check("midrst regrant latency", 32'(seen), 32'd4);
    check("midrst regrant rd0", rd0[1], 32'hDEAD_BEEF);
  endtask

  // ---------------- randomized run against a transaction model ----------------
  task automatic random_run(input int g, input int cycles);
    int unsigned L;
    bit [W-1:0]   rmem [256];
    bit           pend [2];
    bit           rwe [2];
    logic [W-1:0] radr [2];
    logic [W-1:0] rwd [2];
    logic [W-1:0] erd [2];
    bit           act, twe, last, tport;
    logic [W-1:0] tadr, twd, tdata;
    int           gedge, dlen, next_ok;
    logic         e_busy, e_own, e_we, e_d0, e_d1;
    logic [W-1:0] e_adr, e_wd;

    L = lat_of(g);
    act = 0; last = 1; next_ok = 0; tport = 0; twe = 0;
    tadr = '0; twd = '0; tdata = '0; gedge = 0; dlen = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; rwe[p] = 0; radr[p] = '0; rwd[p] = '0; erd[p] = '0;
    end

    for (int n = 0; n < cycles; n++) begin
      // Expected outputs in the cycle after edge n.
      e_busy = 0; e_own = 0; e_we = 0; e_d0 = 0; e_d1 = 0; e_adr = '0; e_wd = '0;
      if (act && n >= gedge && n <= gedge + dlen) begin
        e_busy = 1; e_own = tport; e_adr = tadr; e_wd = twd;
        e_we = twe && (n == gedge);
        if (n == gedge + dlen) begin
          if (tport) e_d1 = 1; else e_d0 = 1;
          if (!twe) erd[tport] = tdata;
        end
      end
      check1($sformatf("rnd g%0d n%0d busy", g, n), busy[g], e_busy);
      check1($sformatf("rnd g%0d n%0d owner", g, n), owner[g], e_own);
      check1($sformatf("rnd g%0d n%0d mem_we", g, n), mem_we[g], e_we);
      check1($sformatf("rnd g%0d n%0d done0", g, n), done0[g], e_d0);
      check1($sformatf("rnd g%0d n%0d done1", g, n), done1[g], e_d1);
      check($sformatf("rnd g%0d n%0d mem_adr", g, n), mem_adr[g], e_adr);
      check($sformatf("rnd g%0d n%0d mem_wd", g, n), mem_wd[g], e_wd);
      check($sformatf("rnd g%0d n%0d rd0", g, n), rd0[g], erd[0]);
      check($sformatf("rnd g%0d n%0d rd1", g, n), rd1[g], erd[1]);

      // Requesters.
      for (int p = 0; p < 2; p++) begin
        bit finishing;
        bit issue;
        finishing = act && (int'(tport) == p) && (n == gedge + dlen);
        issue = 0;
        if (finishing) begin
          pend[p] = 0;
          issue = ($urandom_range(0, 1) == 0);
        end else if (!pend[p]) begin
          issue = ($urandom_range(0, 3) == 0);
        end
        if (issue) begin
          pend[p] = 1;
          rwe[p]  = 1'($urandom_range(0, 1));
          radr[p] = $urandom | 32'h200;
          rwd[p]  = $urandom;
          drive(g, p, 1'b1, rwe[p], radr[p], rwd[p]);
        end else if (!pend[p]) begin
          drive(g, p, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if (act && int'(tport) == p && n >= gedge) begin
          drive(g, p, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end

      // Arbiter at edge n+1.
      if (act && n + 1 > gedge + dlen) act = 0;
      if (!act && n + 1 >= next_ok && (pend[0] || pend[1])) begin
        tport = (pend[0] && pend[1]) ? !last : pend[1];
        twe   = rwe[tport];
        tadr  = radr[tport];
        twd   = rwd[tport];
        gedge = n + 1;
        dlen  = twe ? 1 : int'(L);
        next_ok = gedge + dlen + 2;
        last  = tport;
        act   = 1;
        if (twe) rmem[tadr[9:2]] = twd;
        else     tdata = rmem[tadr[9:2]];
      end
      @(negedge clk);
    end
    drive(g, 0, 1'b0, 1'b0, '0, '0);
    drive(g, 1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{g:0, port:1, we:1, adr:32'h10,  wd:32'h8C02_0004, lat:2, acc:1, rd0:32'h0,         rd1:32'h0};
    vecs[1] = '{g:0, port:0, we:0, adr:32'h10,  wd:32'h1234_5678, lat:2, acc:1, rd0:32'h8C02_0004, rd1:32'h0};
    vecs[2] = '{g:0, port:0, we:1, adr:32'h54,  wd:32'h0000_0007, lat:2, acc:1, rd0:32'h8C02_0004, rd1:32'h0};
    vecs[3] = '{g:0, port:1, we:0, adr:32'h56,  wd:32'h0,         lat:2, acc:1, rd0:32'h8C02_0004, rd1:32'h7};
    vecs[4] = '{g:1, port:0, we:1, adr:32'h100, wd:32'hDEAD_BEEF, lat:2, acc:1, rd0:32'h0,         rd1:32'h0};
    vecs[5] = '{g:1, port:1, we:0, adr:32'h100, wd:32'h0,         lat:4, acc:3, rd0:32'h0,         rd1:32'hDEAD_BEEF};
    vecs[6] = '{g:1, port:0, we:1, adr:32'h54,  wd:32'hA5A5_0001, lat:2, acc:1, rd0:32'h0,         rd1:32'hDEAD_BEEF};
    vecs[7] = '{g:1, port:0, we:0, adr:32'h54,  wd:32'h0,         lat:4, acc:3, rd0:32'hA5A5_0001, rd1:32'hDEAD_BEEF};

    for (int g = 0; g < 2; g++) begin
      drive(g, 0, 1'b0, 1'b0, '0, '0);
      drive(g, 1, 1'b0, 1'b0, '0, '0);
    end

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    tie_test();
    rr_test();
    mid_reset_test();

    do_reset();
    random_run(0, 400);
    do_reset();
    random_run(1, 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
